frame_tx_gen: RTL and testbench
===============================

FRAME_TX_GEN -- requirements
Module: frame_tx_gen

Interface
REQ-001 SHALL have ports: i_clk  in  1  clock, all logic on rising edge.
REQ-002 SHALL have ports: i_rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: i_enable  in  1  generator run enable.
REQ-004 SHALL have ports: i_pl_data  in  8  payload byte; i_pl_valid  in  1  payload byte available; o_pl_ready  out  1  payload byte accepted this cycle.
REQ-005 SHALL have ports: o_data  out  8  framed byte; o_valid  out  1  o_data valid; i_ready  in  1  downstream accepts o_data.
REQ-006 SHALL have ports: o_row_cnt  out  2  row of the byte on o_data; o_col_cnt  out  11  column of the byte on o_data; o_mfas  out  8  current multiframe count.

Function
REQ-007 Frame SHALL be 4 rows x 1041 columns (0..1040), row-major; columns 0..15 overhead (OH), 16..1039 payload, 1040 check byte.
REQ-008 OH bytes: row 0 cols 0..2 = 0xF6; cols 3..5 = 0x28; col 6 = MFAS; all other OH bytes = 0x00.
REQ-009 FSM states: IDLE, OH, PAYLOAD, CHK; IDLE->OH at row 0 col 0 when i_enable=1; OH->PAYLOAD after col 15; PAYLOAD->CHK after col 1039; CHK->OH on the next row; after row 3 col 1040, wrap to row 0 col 0.
REQ-010 An output byte SHALL advance only on a transfer (o_valid & i_ready); on o_valid=1 & i_ready=0, o_data/o_row_cnt/o_col_cnt SHALL hold stable.
REQ-011 o_pl_ready SHALL be 1 only when state=PAYLOAD & i_enable=1 & (o_valid=0 | i_ready=1); a payload byte is consumed on o_pl_ready & i_pl_valid.
REQ-012 Consumed payload byte SHALL appear on o_data exactly 1 cycle later with o_valid=1 (latency 1).
REQ-013 In PAYLOAD with i_pl_valid=0, o_valid SHALL drop to 0 once the current byte transfers and the column SHALL not advance; OH and CHK bytes never wait on upstream.
REQ-014 Check byte (col 1040) SHALL be XOR of that row's 1024 payload bytes; accumulator cleared at col 16 of each row.
REQ-015 MFAS SHALL increment by 1 after the row 3 col 1040 transfer, wrapping 255->0.
REQ-016 i_enable=0 SHALL stop issuing new bytes after any pending byte transfers; position, MFAS and accumulator held; re-enable resumes at the held position.
REQ-017 Counters SHALL be unsigned; col wraps 1040->0 with row+1; row wraps 3->0.

Reset
REQ-018 On i_rst_n=0 (asynchronous): state=IDLE, o_valid=0, o_data=0x00, o_pl_ready=0, o_row_cnt=0, o_col_cnt=0, o_mfas=0, accumulator=0.
REQ-019 Reset mid-frame SHALL abandon the frame; the first frame after release starts at row 0 col 0 with MFAS 0.
REQ-020 Reset release SHALL be treated synchronously, with no output change in the release cycle.

Configuration
REQ-021 Macro FRAME_TX_CHK_EN defined: col 1040 carries the XOR check byte per REQ-014.
REQ-022 FRAME_TX_CHK_EN undefined: col 1040 = 0x00, accumulator logic absent; all other timing identical.

Structure
REQ-023 Package frame_pkg SHALL hold ROWS=4, LAST_COL=1040, OH_COLS=16, FAS_A=0xF6, FAS_B=0x28 and the FSM state typedef.
REQ-024 One sub-module frame_tx_pos (row/col position counter with advance strobe and wrap) SHALL be instantiated; the FSM, muxing and check logic stay in the top.

Verification
REQ-025 Reset, enable, pl_valid=1, ready=1 always -> first 7 bytes F6 F6 F6 28 28 28 00, col 16 = first payload byte, frame repeats every 4164 transfers.
REQ-026 Payload = incrementing 0x00..0xFF (repeating) -> col 1040 check byte = 0x00 on every row (CHK_EN) and 0x00 (no CHK_EN); payload 0x01 only at col 16, else 0x00 -> check byte 0x01.
REQ-027 i_ready low for 5 cycles at row 1 col 500 -> o_data/col held 5 cycles, no payload consumed, no byte lost or duplicated.
REQ-028 i_pl_valid low for 10 cycles at col 100 -> o_valid=0 for those cycles, column stays 100; during OH cols 0..15 pl_valid=0 has no effect.
REQ-029 Run 256 frames -> MFAS at row 0 col 6 goes 0..255 then 0.
REQ-030 Assert i_rst_n=0 at row 2 col 700 -> outputs at reset values immediately; after release, next byte is 0xF6 at row 0 col 0, MFAS 0.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared frame geometry, framing-byte constants and FSM state type for the frame
// transmit generator.
package frame_pkg;

  localparam int         ROWS     = 4;
  localparam logic [10:0] LAST_COL = 11'd1040;
  localparam logic [10:0] OH_COLS  = 11'd16;
  localparam logic [7:0]  FAS_A    = 8'hF6;
  localparam logic [7:0]  FAS_B    = 8'h28;

  typedef enum logic [1:0] {
    IDLE,
    OH,
    PAYLOAD,
    CHK
  } state_t;

  // Overhead byte for a given position; only row 0 carries FAS and MFAS.
  function automatic logic [7:0] oh_byte(input logic [1:0] row, input logic [10:0] col,
                                         input logic [7:0] mfas);
    logic [7:0] b;
    b = 8'h00;
    if (row == 2'd0) begin
      if (col <= 11'd2)      b = FAS_A;
      else if (col <= 11'd5) b = FAS_B;
      else if (col == 11'd6) b = mfas;
    end
    return b;
  endfunction

endpackage

// File: rtl/frame_tx_pos.sv
// Row/column position of the next byte to issue; steps once per advance strobe
// and wraps at the end of each row and of the frame.
module frame_tx_pos
  import frame_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adv,
  output logic [1:0]  row,
  output logic [10:0] col
);

  logic [1:0]  row_reg;
  logic [10:0] col_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_reg <= 2'd0;
      col_reg <= 11'd0;
    end else if (adv) begin
      if (col_reg == LAST_COL) begin
        col_reg <= 11'd0;
        row_reg <= (row_reg == 2'(ROWS - 1)) ? 2'd0 : row_reg + 2'd1;
      end else begin
        col_reg <= col_reg + 11'd1;
      end
    end
  end

  assign row = row_reg;
  assign col = col_reg;

endmodule

// File: rtl/frame_tx_gen.sv
// Frame transmit generator: 4 x 1041 byte frames of overhead, payload and a
// per-row check byte. Define FRAME_TX_CHK_EN to carry the XOR check byte.
module frame_tx_gen
  import frame_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic [7:0]  i_pl_data,
  input  logic        i_pl_valid,
  output logic        o_pl_ready,
  output logic [7:0]  o_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [1:0]  o_row_cnt,
  output logic [10:0] o_col_cnt,
  output logic [7:0]  o_mfas
);

  state_t      state_reg, state_next;
  logic [7:0]  data_reg;
  logic        valid_reg;
  logic [1:0]  row_reg;
  logic [10:0] col_reg;
  logic [7:0]  mfas_reg;

  logic        can_load;
  logic        issue;
  logic [7:0]  issue_data;
  logic [7:0]  chk_byte;
  logic [1:0]  pos_row;
  logic [10:0] pos_col;

  // The output register may take a new byte when empty or when its byte leaves now.
  assign can_load = ~valid_reg | i_ready;

  frame_tx_pos u_pos (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .adv   (issue),
    .row   (pos_row),
    .col   (pos_col)
  );

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    issue_data = 8'h00;
    o_pl_ready = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_enable) state_next = OH;
      end
      OH: begin
        if (i_enable && can_load) begin
          issue      = 1'b1;
          issue_data = oh_byte(pos_row, pos_col, mfas_reg);
          if (pos_col == OH_COLS - 11'd1) state_next = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (i_enable && can_load) begin
          o_pl_ready = 1'b1;
          if (i_pl_valid) begin
            issue      = 1'b1;
            issue_data = i_pl_data;
            if (pos_col == LAST_COL - 11'd1) state_next = CHK;
          end
        end
      end
      CHK: begin
        if (i_enable && can_load) begin
          issue      = 1'b1;
          issue_data = chk_byte;
          state_next = OH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      data_reg  <= 8'h00;
      valid_reg <= 1'b0;
      row_reg   <= 2'd0;
      col_reg   <= 11'd0;
      mfas_reg  <= 8'h00;
    end else begin
      state_reg <= state_next;
      if (issue) begin
        valid_reg <= 1'b1;
        data_reg  <= issue_data;
        row_reg   <= pos_row;
        col_reg   <= pos_col;
      end else if (can_load) begin
        valid_reg <= 1'b0;
      end
      // Multiframe count steps once the last byte of the frame has left.
      if (valid_reg && i_ready && row_reg == 2'(ROWS - 1) && col_reg == LAST_COL)
        mfas_reg <= mfas_reg + 8'd1;
    end
  end

`ifdef FRAME_TX_CHK_EN
  logic [7:0] acc_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_reg <= 8'h00;
    end else if (issue && state_reg == PAYLOAD) begin
      acc_reg <= (pos_col == OH_COLS) ? issue_data : (acc_reg ^ issue_data);
    end
  end

  assign chk_byte = acc_reg;
`else
  assign chk_byte = 8'h00;
`endif

  assign o_data    = data_reg;
  assign o_valid   = valid_reg;
  assign o_row_cnt = row_reg;
  assign o_col_cnt = col_reg;
  assign o_mfas    = mfas_reg;

endmodule

// File: tb/tb_frame_tx_gen.sv
// Self-checking bench for frame_tx_gen: directed and random traffic scored
// against a position-based frame model.
module tb_frame_tx_gen;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_ready;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic [1:0]  row_cnt;
  logic [10:0] col_cnt;
  logic [7:0]  mfas;

  int checks = 0;
  int errors = 0;

  frame_tx_gen dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_enable   (enable),
    .i_pl_data  (pl_data),
    .i_pl_valid (pl_valid),
    .o_pl_ready (pl_ready),
    .o_data     (data),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_row_cnt  (row_cnt),
    .o_col_cnt  (col_cnt),
    .o_mfas     (mfas)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: position of the next expected transfer.
  int         m_row, m_col;
  logic [7:0] m_mfas, m_xor;
  logic [7:0] pl_q[$];
  int         xfer_cnt, last_start;
  logic       pend_v, stall_v, consumed;
  logic [7:0] pend_b, stall_d;
  logic [1:0] stall_r;
  logic [10:0] stall_c;
  int         pl_cnt;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_row = 0; m_col = 0; m_mfas = 8'h00; m_xor = 8'h00;
    pl_q.delete();
    pend_v = 1'b0; stall_v = 1'b0; consumed = 1'b0;
    last_start = -1;
  endtask

  function automatic logic [7:0] exp_oh(input int r, input int c, input logic [7:0] mf);
    if (r != 0) return 8'h00;
    if (c <= 2) return 8'hF6;
    if (c <= 5) return 8'h28;
    if (c == 6) return mf;
    return 8'h00;
  endfunction

  task automatic observe();
    logic [7:0] e;
    chk("mfas", 16'(mfas), 16'(m_mfas));
    if (pend_v) begin
      chk("lat_valid", 16'(valid), 16'd1);
      chk("lat_data", 16'(data), 16'(pend_b));
    end
    if (stall_v) begin
      chk("hold_valid", 16'(valid), 16'd1);
      chk("hold_data", 16'(data), 16'(stall_d));
      chk("hold_row", 16'(row_cnt), 16'(stall_r));
      chk("hold_col", 16'(col_cnt), 16'(stall_c));
    end
    if (valid && !ready) chk("pl_ready_stall", 16'(pl_ready), 16'd0);
    if (!enable) chk("pl_ready_disabled", 16'(pl_ready), 16'd0);
    if (valid && ready) begin
      if (m_col < 16) begin
        e = exp_oh(m_row, m_col, m_mfas);
      end else if (m_col < 1040) begin
        chk("pl_available", 16'(pl_q.size() > 0), 16'd1);
        e = (pl_q.size() > 0) ? pl_q.pop_front() : 8'h00;
        m_xor = (m_col == 16) ? e : (m_xor ^ e);
      end else begin
`ifdef FRAME_TX_CHK_EN
        e = m_xor;
`else
        e = 8'h00;
`endif
      end
      chk("data", 16'(data), 16'(e));
      chk("row", 16'(row_cnt), 16'(m_row));
      chk("col", 16'(col_cnt), 16'(m_col));
      if (m_row == 0 && m_col == 0) begin
        if (last_start >= 0) chk("frame_period", 16'(xfer_cnt - last_start), 16'd4164);
        last_start = xfer_cnt;
      end
      xfer_cnt++;
      if (m_col == 1040) begin
        m_col = 0;
        if (m_row == 3) begin
          m_row = 0;
          m_mfas = m_mfas + 8'd1;
        end else begin
          m_row++;
        end
      end else begin
        m_col++;
      end
    end
    pend_v   = pl_ready && pl_valid;
    pend_b   = pl_data;
    consumed = pend_v;
    if (pend_v) pl_q.push_back(pl_data);
    stall_v = valid && !ready;
    stall_d = data;
    stall_r = row_cnt;
    stall_c = col_cnt;
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 16'(valid), 16'd0);
    chk({tag, "_data"}, 16'(data), 16'h00);
    chk({tag, "_pl_ready"}, 16'(pl_ready), 16'd0);
    chk({tag, "_row"}, 16'(row_cnt), 16'd0);
    chk({tag, "_col"}, 16'(col_cnt), 16'd0);
    chk({tag, "_mfas"}, 16'(mfas), 16'd0);
  endtask

  initial begin
    bit ready_done, valid_done, found;
    int hold_n;

    rst_n = 1'b0; enable = 1'b0; pl_data = 8'h00; pl_valid = 1'b0; ready = 1'b0;
    xfer_cnt = 0; pl_cnt = 0;
    model_reset();
    #1;
    chk_reset_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_valid", 16'(valid), 16'd0);
    @(posedge clk); #1;
    $display("step reset: checks=%0d errors=%0d", checks, errors);

    // Directed streaming: incrementing payload for one frame, then a single 0x01 per row.
    enable = 1'b1; ready = 1'b1; pl_valid = 1'b1;
    ready_done = 1'b0; valid_done = 1'b0;
    for (int n = 0; n < 9000; n++) begin
      pl_data = (pl_cnt < 4096) ? 8'(pl_cnt) : ((pl_cnt % 1024 == 0) ? 8'h01 : 8'h00);
      tick();
      if (consumed) pl_cnt++;
      if (!ready_done && valid && row_cnt == 2'd1 && col_cnt == 11'd500) begin
        ready_done = 1'b1;
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          tick();
          if (consumed) pl_cnt++;
        end
        ready = 1'b1;
      end
      if (!valid_done && valid && row_cnt == 2'd0 && col_cnt == 11'd99) begin
        valid_done = 1'b1;
        pl_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
          tick();
          if (k > 0) chk("pl_gap_valid", 16'(valid), 16'd0);
        end
        pl_valid = 1'b1;
      end
    end
    chk("ready_stall_reached", 16'(ready_done), 16'd1);
    chk("pl_gap_reached", 16'(valid_done), 16'd1);
    $display("step stream: transfers=%0d checks=%0d errors=%0d", xfer_cnt, checks, errors);

    // Random handshakes, payload and enable gaps.
    hold_n = 0;
    for (int n = 0; n < 20000; n++) begin
      ready    = ($urandom_range(0, 3) != 0);
      pl_valid = ($urandom_range(0, 3) != 0);
      pl_data  = 8'($urandom);
      if (hold_n > 0) begin
        hold_n--;
        enable = (hold_n == 0);
      end else if ($urandom_range(0, 199) == 0) begin
        hold_n = $urandom_range(1, 20);
        enable = 1'b0;
      end
      tick();
    end
    enable = 1'b1;
    $display("step random: transfers=%0d checks=%0d errors=%0d", xfer_cnt, checks, errors);

    // Reset in the middle of row 2.
    ready = 1'b1; pl_valid = 1'b1; found = 1'b0;
    for (int n = 0; n < 6000 && !found; n++) begin
      pl_data = 8'($urandom);
      tick();
      if (valid && row_cnt == 2'd2 && col_cnt == 11'd700) found = 1'b1;
    end
    chk("reach_row2_col700", 16'(found), 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrelease_valid", 16'(valid), 16'd0);
    @(posedge clk); #1;
    found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      if (valid) begin
        found = 1'b1;
        chk("restart_data", 16'(data), 16'hF6);
        chk("restart_row", 16'(row_cnt), 16'd0);
        chk("restart_col", 16'(col_cnt), 16'd0);
        chk("restart_mfas", 16'(mfas), 16'd0);
      end
      tick();
    end
    chk("restart_seen", 16'(found), 16'd1);
    for (int n = 0; n < 5000; n++) begin
      pl_data = 8'($urandom);
      tick();
    end
    $display("step midreset: transfers=%0d checks=%0d errors=%0d", xfer_cnt, checks, errors);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
